// File: rtl/fpgavn_lat_pkg.sv
// Shared constants for the latched-read holding buffer: state encoding and default width.
package fpgavn_lat_pkg;

  localparam int LAT_SIZE = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } lat_st_e;

endpackage

// File: rtl/lat_rd_slot.sv
// One storage word with load enable; resets asynchronously to RST_VAL.
module lat_rd_slot
  import fpgavn_lat_pkg::*;
#(
  parameter int              SIZE    = LAT_SIZE,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/s_lat_rd.sv
// Two-entry holding buffer between an ena-strobed producer and a valid/ready reader.
// Optional sticky overflow flag enabled by defining S_LAT_RD_OVF_EN.
//
// state    | meaning
// ST_EMPTY | no word held, odat keeps last value
// ST_ONE   | head slot valid
// ST_FULL  | head and tail valid, unread write is dropped
module s_lat_rd
  import fpgavn_lat_pkg::*;
#(
  parameter int              SIZE    = LAT_SIZE,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [SIZE-1:0] idat,
  output logic            ovld,
  input  logic            ordy,
  output logic [SIZE-1:0] odat,
  output logic            ovf,
  input  logic            ovf_clr
);

  lat_st_e         state_q, state_d;
  logic            hd_ld, hd_sel_tail, tl_ld, ovf_evt;
  logic [SIZE-1:0] hd_d, tl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (ena) state_d = ST_ONE;
      ST_ONE: begin
        if (ena && !ordy)      state_d = ST_FULL;
        else if (!ena && ordy) state_d = ST_EMPTY;
      end
      ST_FULL:  if (!ena && ordy) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // ovld depends only on registered state; ena/ordy only steer slot loads
  always_comb begin
    ovld        = (state_q != ST_EMPTY);
    hd_ld       = 1'b0;
    hd_sel_tail = 1'b0;
    tl_ld       = 1'b0;
    ovf_evt     = 1'b0;
    unique case (state_q)
      ST_EMPTY: hd_ld = ena;
      ST_ONE: begin
        hd_ld = ena & ordy;
        tl_ld = ena & ~ordy;
      end
      ST_FULL: begin
        hd_ld       = ordy;
        hd_sel_tail = 1'b1;
        tl_ld       = ena & ordy;
        ovf_evt     = ena & ~ordy;
      end
      default: ;
    endcase
  end

  assign hd_d = hd_sel_tail ? tl_q : idat;

  lat_rd_slot #(.SIZE(SIZE), .RST_VAL(RST_VAL)) u_head (
    .clk (clk),
    .rst (rst),
    .ld  (hd_ld),
    .d   (hd_d),
    .q   (odat)
  );

  lat_rd_slot #(.SIZE(SIZE), .RST_VAL(RST_VAL)) u_tail (
    .clk (clk),
    .rst (rst),
    .ld  (tl_ld),
    .d   (idat),
    .q   (tl_q)
  );

`ifdef S_LAT_RD_OVF_EN
  logic ovf_q;

  // a drop on the same edge as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf_q <= 1'b0;
    else if (ovf_evt) ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_clr ^ ovf_evt;
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_s_lat_rd.sv
// Directed bench for s_lat_rd; ovf expectations follow S_LAT_RD_OVF_EN.
module tb_s_lat_rd;
  import fpgavn_lat_pkg::*;

`ifdef S_LAT_RD_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] idat = 8'h00;
  logic       ordy = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       ovld, ovf;
  logic [7:0] odat;
  int         n_cmp = 0;
  int         n_bad = 0;

  s_lat_rd #(.SIZE(8), .RST_VAL(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .idat    (idat),
    .ovld    (ovld),
    .ordy    (ordy),
    .odat    (odat),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  // advance one edge; inputs and samples sit 1 time unit after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (ovld !== 1'b0) begin n_bad++; $display("FAIL rst0_vld got %0b exp 0", ovld); end
    n_cmp++; if (odat !== 8'h00) begin n_bad++; $display("FAIL rst0_dat got %h exp 00", odat); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst0_ovf got %0b exp 0", ovf); end
    rst = 1'b0;
    tick();
    ena = 1'b1; idat = 8'h5A; tick();
    idat = 8'h3C; tick();
    idat = 8'h77; tick();
    ena = 1'b0;
    n_cmp++; if (ovf !== EXP_OVF) begin n_bad++; $display("FAIL rst_pre_ovf got %0b exp %0b", ovf, EXP_OVF); end
    n_cmp++; if (odat !== 8'h5A) begin n_bad++; $display("FAIL rst_pre_dat got %h exp 5a", odat); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ovld !== 1'b0) begin n_bad++; $display("FAIL rst_mid_vld got %0b exp 0", ovld); end
    n_cmp++; if (odat !== 8'h00) begin n_bad++; $display("FAIL rst_mid_dat got %h exp 00", odat); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ovf got %0b exp 0", ovf); end
    #2 rst = 1'b0;
    ena = 1'b1; idat = 8'hA5;
    tick();
    ena = 1'b0;
    n_cmp++; if (ovld !== 1'b1) begin n_bad++; $display("FAIL rst_a5_vld got %0b exp 1", ovld); end
    n_cmp++; if (odat !== 8'hA5) begin n_bad++; $display("FAIL rst_a5_dat got %h exp a5", odat); end
    ordy = 1'b1; tick(); ordy = 1'b0;
    n_cmp++; if (ovld !== 1'b0) begin n_bad++; $display("FAIL rst_drain_vld got %0b exp 0", ovld); end
  endtask

  task automatic test_backpressure();
    ordy = 1'b0; ena = 1'b1;
    idat = 8'h11; tick();
    idat = 8'h22; tick();
    ena = 1'b0;
    n_cmp++; if (ovld !== 1'b1) begin n_bad++; $display("FAIL bp_vld got %0b exp 1", ovld); end
    n_cmp++; if (odat !== 8'h11) begin n_bad++; $display("FAIL bp_dat0 got %h exp 11", odat); end
    tick();
    n_cmp++; if (odat !== 8'h11) begin n_bad++; $display("FAIL bp_hold got %h exp 11", odat); end
    ordy = 1'b1; tick();
    n_cmp++; if (ovld !== 1'b1) begin n_bad++; $display("FAIL bp_vld1 got %0b exp 1", ovld); end
    n_cmp++; if (odat !== 8'h22) begin n_bad++; $display("FAIL bp_dat1 got %h exp 22", odat); end
    tick(); ordy = 1'b0;
    n_cmp++; if (ovld !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %0b exp 0", ovld); end
    n_cmp++; if (odat !== 8'h22) begin n_bad++; $display("FAIL bp_keep got %h exp 22", odat); end
  endtask

  task automatic test_streaming();
    ena = 1'b1; ordy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      idat = 8'(k);
      tick();
      n_cmp++; if (ovld !== 1'b1 || odat !== 8'(k)) begin
        n_bad++; $display("FAIL stream_%0d got vld=%0b dat=%h exp vld=1 dat=%h", k, ovld, odat, 8'(k));
      end
    end
    ena = 1'b0; tick(); ordy = 1'b0;
    n_cmp++; if (ovld !== 1'b0) begin n_bad++; $display("FAIL stream_end got %0b exp 0", ovld); end
    n_cmp++; if (odat !== 8'h0F) begin n_bad++; $display("FAIL stream_keep got %h exp 0f", odat); end
  endtask

  task automatic test_overflow();
    ordy = 1'b0; ena = 1'b1;
    idat = 8'h01; tick();
    idat = 8'h02; tick();
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_full got %0b exp 0", ovf); end
    idat = 8'h03; tick();
    ena = 1'b0;
    n_cmp++; if (ovf !== EXP_OVF) begin n_bad++; $display("FAIL ovf_set got %0b exp %0b", ovf, EXP_OVF); end
    n_cmp++; if (odat !== 8'h01) begin n_bad++; $display("FAIL ovf_dat0 got %h exp 01", odat); end
    ordy = 1'b1; tick();
    n_cmp++; if (ovld !== 1'b1 || odat !== 8'h02) begin n_bad++; $display("FAIL ovf_dat1 got vld=%0b dat=%h exp vld=1 dat=02", ovld, odat); end
    tick(); ordy = 1'b0;
    n_cmp++; if (ovld !== 1'b0) begin n_bad++; $display("FAIL ovf_drain got %0b exp 0", ovld); end
    n_cmp++; if (ovf !== EXP_OVF) begin n_bad++; $display("FAIL ovf_sticky got %0b exp %0b", ovf, EXP_OVF); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got %0b exp 0", ovf); end
    // clear and drop on the same edge: set wins
    ena = 1'b1;
    idat = 8'h0A; tick();
    idat = 8'h0B; tick();
    idat = 8'h0C; ovf_clr = 1'b1; tick();
    ena = 1'b0; ovf_clr = 1'b0;
    n_cmp++; if (ovf !== EXP_OVF) begin n_bad++; $display("FAIL ovf_setwins got %0b exp %0b", ovf, EXP_OVF); end
    ordy = 1'b1; tick(); tick(); ordy = 1'b0;
    n_cmp++; if (ovld !== 1'b0 || odat !== 8'h0B) begin n_bad++; $display("FAIL ovf_sw_drain got vld=%0b dat=%h exp vld=0 dat=0b", ovld, odat); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
  endtask

  task automatic test_passthrough();
    ordy = 1'b0; ena = 1'b1;
    idat = 8'h01; tick();
    idat = 8'h02; tick();
    idat = 8'h03; ordy = 1'b1; tick();
    ena = 1'b0;
    n_cmp++; if (ovld !== 1'b1 || odat !== 8'h02) begin n_bad++; $display("FAIL pt_dat1 got vld=%0b dat=%h exp vld=1 dat=02", ovld, odat); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL pt_ovf got %0b exp 0", ovf); end
    tick();
    n_cmp++; if (ovld !== 1'b1 || odat !== 8'h03) begin n_bad++; $display("FAIL pt_dat2 got vld=%0b dat=%h exp vld=1 dat=03", ovld, odat); end
    tick(); ordy = 1'b0;
    n_cmp++; if (ovld !== 1'b0) begin n_bad++; $display("FAIL pt_empty got %0b exp 0", ovld); end
  endtask

  initial begin
    #1;
    test_reset();
    test_backpressure();
    test_streaming();
    test_overflow();
    test_passthrough();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
